// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequential radix-2 Booth multiplier for signed WIDTH-bit
// operands, producing a 2*WIDTH-bit product over WIDTH RUN cycles.
// Optional feature macro: MULT_ABORT_EN adds the abort input, which cancels
// a multiply in progress without touching the result registers.
//
// Handshake: start is sampled only in IDLE, and m/r are captured on that
// same edge. busy is high for exactly WIDTH cycles. done is a one-cycle
// pulse, and prod_hi/prod_lo/overflow are valid from that cycle until the
// next result is loaded. There is no backpressure, and a start seen outside
// IDLE is dropped, not queued.
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] r,
`ifdef MULT_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // P = {upper (WIDTH+1), multiplier (WIDTH), Booth guard bit}
  localparam int PW = 2 * WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH:0]   mcand;
  logic [PW-1:0]    p;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   upper;
  logic [WIDTH:0]   upper_n;
  logic [PW-1:0]    p_sum;
  logic [PW-1:0]    p_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]   prod_top;
  logic             ovf_next;
  logic             last_step;
  logic             run_abort;

`ifdef MULT_ABORT_EN
  assign run_abort = abort;
`else
  assign run_abort = 1'b0;
`endif

  assign state_dbg = state;

  // One Booth step: add/subtract the multiplicand on the upper part, then
  // arithmetic-shift the whole register right by one bit. The upper part is
  // WIDTH+1 bits wide so that negating the most negative m cannot wrap.
  always_comb begin
    upper    = p[PW-1:WIDTH+1];
    upper_n  = upper;
    case (p[1:0])
      2'b01:   upper_n = upper + mcand;
      2'b10:   upper_n = upper - mcand;
      default: upper_n = upper;
    endcase
    p_sum     = {upper_n, p[WIDTH:0]};
    p_next    = {p_sum[PW-1], p_sum[PW-1:1]};
    // P[2*WIDTH:1] after the shift equals p_sum[2*WIDTH+1:2]
    prod      = p_sum[2*WIDTH+1:2];
    prod_top  = prod[2*WIDTH-1:WIDTH-1];
    ovf_next  = ~((&prod_top) | ~(|prod_top));
    last_step = (cnt == CW'(WIDTH - 1));
  end

  // Control FSM with registered busy/done and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mcand    <= '0;
      p        <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      prod_hi  <= '0;
      prod_lo  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= {m[WIDTH-1], m};
            p     <= {{(WIDTH + 1){1'b0}}, r, 1'b0};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (run_abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            p   <= p_next;
            cnt <= cnt + 1'b1;
            if (last_step) begin
              prod_hi  <= prod[2*WIDTH-1:WIDTH];
              prod_lo  <= prod[WIDTH-1:0];
              overflow <= ovf_next;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: directed corner products, mid-run start,
// reset during RUN, optional abort (MULT_ABORT_EN), then random operands.
module tb_mult_seq_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] m = '0;
  logic [W-1:0] r = '0;
`ifdef MULT_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] prod_hi;
  logic [W-1:0] prod_lo;
  logic         overflow;
  logic [1:0]   state_dbg;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .m         (m),
    .r         (r),
`ifdef MULT_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .prod_hi   (prod_hi),
    .prod_lo   (prod_lo),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W:0] exp_q[$];
  logic [2*W:0] last_res = '0;
  logic [2*W:0] exp_e;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // reference: full signed product, overflow when it differs from the
  // sign extension of its low WIDTH bits
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb, pr;
    logic ovf;
    sa  = {{W{a[W-1]}}, a};
    sb  = {{W{b[W-1]}}, b};
    pr  = sa * sb;
    ovf = (pr != {{W{pr[W-1]}}, pr[W-1:0]});
    return {ovf, pr};
  endfunction

  // scoreboard: every done pops one expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_e = exp_q.pop_front();
        check("prod_hi", prod_hi, exp_e[2*W-1:W]);
        check("prod_lo", prod_lo, exp_e[W-1:0]);
        check("overflow", overflow, exp_e[2*W]);
        last_res = exp_e;
      end
    end
  end

  // drivers
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    m = a;
    r = b;
    start = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    m = $urandom;
    r = $urandom;
  endtask

  // waits for done after an accepted start; optional junk start at step inject
  task automatic wait_done(input int inject);
    int lat;
    int bcnt;
    lat = 0;
    bcnt = 0;
    while (lat < W + 8) begin
      @(negedge clk);
      lat++;
      if (lat == inject) begin
        start = 1'b1;
        m = $urandom;
        r = $urandom;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (busy) bcnt++;
    end
    start = 1'b0;
    check("latency", lat, W + 1);
    check("busy_cycles", bcnt, W);
    check("state_done", state_dbg, 2);
  endtask

  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input int inject);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("hold", {overflow, prod_hi, prod_lo}, last_res);
    launch(a, b);
    wait_done(inject);
  endtask

  task automatic reset_mid_run(input logic [W-1:0] a, input logic [W-1:0] b);
    int seen;
    @(negedge clk);
    m = a;
    r = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", prod_hi, 0);
    check("rst_lo", prod_lo, 0);
    check("rst_ovf", overflow, 0);
    check("rst_state", state_dbg, 0);
    last_res = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no_done_after_reset", seen, 0);
  endtask

`ifdef MULT_ABORT_EN
  task automatic abort_mid_run(input logic [W-1:0] a, input logic [W-1:0] b);
    int seen;
    @(negedge clk);
    m = a;
    r = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_state", state_dbg, 0);
    seen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no_done_after_abort", seen, 0);
    check("abort_hold", {overflow, prod_hi, prod_lo}, last_res);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", prod_hi, 0);
    check("reset_lo", prod_lo, 0);
    check("reset_ovf", overflow, 0);
    check("reset_state", state_dbg, 0);

    // first start on the first edge with reset released
    rst_n = 1'b1;
    launch(32'd3, 32'd4);
    wait_done(-1);

    // corner products, each issued back-to-back
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    do_mult(32'h8000_0000, 32'h8000_0000, -1);
    do_mult(32'h7FFF_FFFF, 32'd2, -1);
    do_mult(32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_mult(32'h8000_0000, 32'd1, -1);
    do_mult(32'd0, 32'h1234_5678, -1);
    do_mult(32'h7FFF_FFFF, 32'h7FFF_FFFF, -1);

    // start pulsed at step 10 must be ignored, then back-to-back accept
    do_mult(32'd1234567, 32'hFFFF_FF85, 10);
    do_mult(32'd99, 32'd101, -1);

    reset_mid_run(32'd5, 32'd7);
    do_mult(32'hFFFF_FFF9, 32'd6, -1);

`ifdef MULT_ABORT_EN
    abort_mid_run(32'd11, 32'd13);
    do_mult(32'd17, 32'd19, -1);
`endif

    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) a = W'($urandom_range(0, 255)) - 32'd128;
      if (i % 4 == 2) b = W'($urandom_range(0, 65535));
      do_mult(a, b, -1);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
